// File: rtl/mmio_timer_if.sv
// mmio_timer_if: CPU data-bus signals seen by the memory-mapped timer.
//   addr      CPU data address
//   wdata     CPU store data
//   mem_read  load strobe
//   mem_write store strobe
//   rdata     load data returned by the slave (0 when not selected)
//   sel       slave decode hit
// The master modport is the CPU side; the slave modport is the timer side.
`timescale 1ns/1ps

interface mmio_timer_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] rdata;
  logic        sel;

  modport master (
    output addr, wdata, mem_read, mem_write,
    input  rdata, sel
  );

  modport slave (
    input  addr, wdata, mem_read, mem_write,
    output rdata, sel
  );
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped down-counting timer in a 16-byte window of the
// CPU data address space. Single-cycle loads (combinational rdata) and
// stores (committed on the rising clk edge). Level interrupt on expiry.
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    mmio_timer_if.slave: addr, wdata, mem_read, mem_write in;
//          rdata, sel out
//   irq    STATUS.EXPIRED & CTRL.IRQ_EN (registers only)
// Register map (word offset = addr[3:2]):
//   0x0 CTRL   [0]=EN [1]=AUTO [2]=IRQ_EN [8+:PRESCALE_W]=PRESCALE
//   0x4 LOAD   reload value
//   0x8 COUNT  current count
//   0xC STATUS [0]=EXPIRED, write-1-to-clear
`timescale 1ns/1ps

module mmio_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          PRESCALE_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  mmio_timer_if.slave  bus,
  output logic         irq
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [PRESCALE_W-1:0] PRESC_ONE = PRESCALE_W'(1);

  state_t                r_state, w_state_next;
  logic                  r_auto, w_auto_next;
  logic                  r_irq_en, w_irq_en_next;
  logic [PRESCALE_W-1:0] r_prescale, w_prescale_next;
  logic [PRESCALE_W-1:0] r_presc, w_presc_next;
  logic [31:0]           r_load, w_load_next;
  logic [31:0]           r_count, w_count_next;
  logic                  r_expired, w_expired_next;

  logic        w_wr;
  logic        w_wr_ctrl, w_wr_load, w_wr_count, w_wr_status;
  logic        w_tick;
  logic [31:0] w_ctrl_rd;
  logic [31:0] w_rd_data;

  // ---------------- decode ----------------
  assign bus.sel     = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign w_wr        = bus.mem_write & bus.sel;
  assign w_wr_ctrl   = w_wr & (bus.addr[3:2] == 2'd0);
  assign w_wr_load   = w_wr & (bus.addr[3:2] == 2'd1);
  assign w_wr_count  = w_wr & (bus.addr[3:2] == 2'd2);
  assign w_wr_status = w_wr & (bus.addr[3:2] == 2'd3);

  // Tick on the cycle the prescaler reaches PRESCALE (every cycle when 0).
  assign w_tick = (r_state == S_RUN) && (r_presc == r_prescale);

  // ---------------- next-state / register updates ----------------
  always_comb begin
    w_state_next    = r_state;
    w_auto_next     = r_auto;
    w_irq_en_next   = r_irq_en;
    w_prescale_next = r_prescale;
    w_presc_next    = r_presc;
    w_load_next     = r_load;
    w_count_next    = r_count;
    w_expired_next  = r_expired;

    // LOAD is resolved first so an auto-reload on this edge sees new wdata.
    if (w_wr_load) begin
      w_load_next = bus.wdata;
    end

    if (w_wr_ctrl) begin
      w_auto_next     = bus.wdata[1];
      w_irq_en_next   = bus.wdata[2];
      w_prescale_next = bus.wdata[8 +: PRESCALE_W];
    end

    // Clear before expiry is considered, so a same-edge expiry wins.
    if (w_wr_status && bus.wdata[0]) begin
      w_expired_next = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (w_wr_ctrl && bus.wdata[0]) begin
          w_state_next = S_RUN;
          w_count_next = r_load;
          w_presc_next = '0;
        end
      end
      S_RUN: begin
        w_presc_next = w_tick ? '0 : (r_presc + PRESC_ONE);
        // A CPU write to COUNT on a tick edge suppresses the tick's effect.
        if (w_tick && !w_wr_count) begin
          if (r_count != 32'd0) begin
            w_count_next = r_count - 32'd1;
          end else begin
            w_expired_next = 1'b1;
            if (r_auto) begin
              w_count_next = w_load_next;
            end else begin
              w_state_next = S_IDLE;
              w_presc_next = '0;
            end
          end
        end
        // Disabling holds COUNT where it is; expiry on this edge still sticks.
        if (w_wr_ctrl && !bus.wdata[0]) begin
          w_state_next = S_IDLE;
          w_presc_next = '0;
          w_count_next = r_count;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    if (w_wr_count) begin
      w_count_next = bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_auto     <= 1'b0;
      r_irq_en   <= 1'b0;
      r_prescale <= '0;
      r_presc    <= '0;
      r_load     <= 32'd0;
      r_count    <= 32'd0;
      r_expired  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_auto     <= w_auto_next;
      r_irq_en   <= w_irq_en_next;
      r_prescale <= w_prescale_next;
      r_presc    <= w_presc_next;
      r_load     <= w_load_next;
      r_count    <= w_count_next;
      r_expired  <= w_expired_next;
    end
  end

  // ---------------- read path ----------------
  // EN is not stored separately: it is exactly "FSM in RUN".
  always_comb begin
    w_ctrl_rd                    = '0;
    w_ctrl_rd[0]                 = (r_state == S_RUN);
    w_ctrl_rd[1]                 = r_auto;
    w_ctrl_rd[2]                 = r_irq_en;
    w_ctrl_rd[8 +: PRESCALE_W]   = r_prescale;
  end

  always_comb begin
    w_rd_data = '0;
    case (bus.addr[3:2])
      2'd0:    w_rd_data = w_ctrl_rd;
      2'd1:    w_rd_data = r_load;
      2'd2:    w_rd_data = r_count;
      default: w_rd_data = {31'd0, r_expired};
    endcase
  end

  assign bus.rdata = (bus.mem_read & bus.sel) ? w_rd_data : 32'd0;

  assign irq = r_expired & r_irq_en;

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed, table-driven self-checking bench for mmio_timer.
`timescale 1ns/1ps

module tb_mmio_timer;

  localparam logic [31:0] BASE   = 32'hFFFF_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_LOAD = BASE + 32'h4;
  localparam logic [31:0] A_CNT  = BASE + 32'h8;
  localparam logic [31:0] A_STAT = BASE + 32'hC;
  localparam logic [31:0] A_MISS = BASE + 32'h10;

  logic clk;
  logic reset;
  logic irq;

  mmio_timer_if bus();

  mmio_timer #(
    .BASE_ADDR  (BASE),
    .PRESCALE_W (8)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Store committed on the next rising edge; returns 1 time unit after it.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.addr      = a;
    bus.wdata     = d;
    bus.mem_write = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_write = 1'b0;
    bus.wdata     = 32'd0;
  endtask

  // Combinational load, no clock edge consumed.
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.addr     = a;
    bus.mem_read = 1'b1;
    #1;
    d            = bus.rdata;
    bus.mem_read = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    logic        exp_sel;
  } vec_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_count;
    logic [31:0] exp_status;
  } step_t;

  vec_t  vecs[17];
  step_t steps[22];

  initial begin
    logic [31:0] d;
    n_cmp  = 0;
    n_fail = 0;

    // ---------------- idle register-access vectors ----------------
    vecs[0]  = '{0, A_CTRL,       32'h0,          32'h0,          1'b1};
    vecs[1]  = '{0, A_LOAD,       32'h0,          32'h0,          1'b1};
    vecs[2]  = '{0, A_CNT,        32'h0,          32'h0,          1'b1};
    vecs[3]  = '{0, A_STAT,       32'h0,          32'h0,          1'b1};
    vecs[4]  = '{1, A_LOAD,       32'hDEAD_BEEF,  32'h0,          1'b1};
    vecs[5]  = '{0, A_LOAD,       32'h0,          32'hDEAD_BEEF,  1'b1};
    vecs[6]  = '{0, A_LOAD + 1,   32'h0,          32'hDEAD_BEEF,  1'b1};
    vecs[7]  = '{1, A_CNT,        32'h1234_5678,  32'h0,          1'b1};
    vecs[8]  = '{0, A_CNT + 3,    32'h0,          32'h1234_5678,  1'b1};
    vecs[9]  = '{1, A_CTRL,       32'hFFFF_AAF6,  32'h0,          1'b1};
    vecs[10] = '{0, A_CTRL,       32'h0,          32'h0000_AA06,  1'b1};
    vecs[11] = '{1, A_MISS,       32'hFFFF_FFFF,  32'h0,          1'b0};
    vecs[12] = '{0, A_MISS,       32'h0,          32'h0,          1'b0};
    vecs[13] = '{0, A_CTRL,       32'h0,          32'h0000_AA06,  1'b1};
    vecs[14] = '{1, A_STAT,       32'h1,          32'h0,          1'b1};
    vecs[15] = '{0, A_STAT,       32'h0,          32'h0,          1'b1};
    vecs[16] = '{0, 32'h0000_0008, 32'h0,         32'h0,          1'b0};

    // ---------------- auto-reload / race steps (LOAD=1, PRESCALE=1) ----------------
    // index i is the i+1-th edge after enable
    steps[0]  = '{0, A_CNT,  32'h0,   32'd1,  32'd0};
    steps[1]  = '{0, A_CNT,  32'h0,   32'd0,  32'd0};
    steps[2]  = '{0, A_CNT,  32'h0,   32'd0,  32'd0};
    steps[3]  = '{0, A_CNT,  32'h0,   32'd1,  32'd1};  // first expiry, 4 cycles
    steps[4]  = '{1, A_STAT, 32'h1,   32'd1,  32'd0};  // clear
    steps[5]  = '{0, A_CNT,  32'h0,   32'd0,  32'd0};
    steps[6]  = '{0, A_CNT,  32'h0,   32'd0,  32'd0};
    steps[7]  = '{0, A_CNT,  32'h0,   32'd1,  32'd1};  // second expiry
    steps[8]  = '{1, A_STAT, 32'h1,   32'd1,  32'd0};
    steps[9]  = '{0, A_CNT,  32'h0,   32'd0,  32'd0};
    steps[10] = '{0, A_CNT,  32'h0,   32'd0,  32'd0};
    steps[11] = '{1, A_STAT, 32'h1,   32'd1,  32'd1};  // clear on expiry edge
    steps[12] = '{1, A_STAT, 32'h1,   32'd1,  32'd0};  // clear next cycle
    steps[13] = '{0, A_CNT,  32'h0,   32'd0,  32'd0};
    steps[14] = '{0, A_CNT,  32'h0,   32'd0,  32'd0};
    steps[15] = '{1, A_CNT,  32'd10,  32'd10, 32'd0};  // COUNT write on expiry tick
    steps[16] = '{0, A_CNT,  32'h0,   32'd10, 32'd0};
    steps[17] = '{0, A_CNT,  32'h0,   32'd9,  32'd0};
    steps[18] = '{1, A_CTRL, 32'h103, 32'd9,  32'd0};  // EN=1 in RUN: no reload
    steps[19] = '{0, A_CNT,  32'h0,   32'd8,  32'd0};
    steps[20] = '{1, A_CTRL, 32'h0,   32'd8,  32'd0};  // disable: COUNT holds
    steps[21] = '{0, A_CNT,  32'h0,   32'd8,  32'd0};

    bus.addr      = 32'd0;
    bus.wdata     = 32'd0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;

    // ---------------- reset ----------------
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reg("rst_ctrl",   A_CTRL, 32'd0);
    check_reg("rst_load",   A_LOAD, 32'd0);
    check_reg("rst_count",  A_CNT,  32'd0);
    check_reg("rst_status", A_STAT, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b1;
    tick();

    // ---------------- table vectors ----------------
    for (int i = 0; i < 17; i++) begin
      bus.addr = vecs[i].addr;
      #1;
      check($sformatf("vec%0d_sel", i), {31'd0, bus.sel}, {31'd0, vecs[i].exp_sel});
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].data);
        $display("vec %0d: write 0x%08h <= 0x%08h", i, vecs[i].addr, vecs[i].data);
      end else begin
        bus_read(vecs[i].addr, d);
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
        $display("vec %0d: read  0x%08h -> 0x%08h", i, vecs[i].addr, d);
      end
    end
    // rdata must be 0 without mem_read, even when selected
    bus.addr     = A_LOAD;
    bus.mem_read = 1'b0;
    #1;
    check("no_read_rdata", bus.rdata, 32'd0);
    check("idle_irq", {31'd0, irq}, 32'd0);
    bus_write(A_CTRL, 32'h0);

    // ---------------- one-shot: LOAD=3, CTRL=0x5 ----------------
    bus_write(A_LOAD, 32'd3);
    bus_write(A_CTRL, 32'h5);
    check_reg("os_count_e0", A_CNT, 32'd3);
    for (int c = 2; c >= 0; c--) begin
      tick();
      check_reg($sformatf("os_count_%0d", c), A_CNT, c[31:0]);
      check_reg($sformatf("os_status_%0d", c), A_STAT, 32'd0);
      check($sformatf("os_irq_%0d", c), {31'd0, irq}, 32'd0);
    end
    tick();
    check_reg("os_status_exp", A_STAT, 32'd1);
    check("os_irq_exp", {31'd0, irq}, 32'd1);
    check_reg("os_ctrl_exp", A_CTRL, 32'h4);
    check_reg("os_count_exp", A_CNT, 32'd0);
    repeat (3) tick();
    check_reg("os_count_hold", A_CNT, 32'd0);
    bus_write(A_STAT, 32'h1);
    check_reg("os_status_clr", A_STAT, 32'd0);
    check("os_irq_clr", {31'd0, irq}, 32'd0);
    $display("one-shot sequence done");

    // ---------------- auto-reload, prescale, races ----------------
    bus_write(A_LOAD, 32'd1);
    bus_write(A_CTRL, 32'h103);
    for (int i = 0; i < 22; i++) begin
      if (steps[i].wr) bus_write(steps[i].addr, steps[i].data);
      else             tick();
      check_reg($sformatf("auto%0d_count", i + 1), A_CNT, steps[i].exp_count);
      check_reg($sformatf("auto%0d_status", i + 1), A_STAT, steps[i].exp_status);
      check($sformatf("auto%0d_irq", i + 1), {31'd0, irq}, 32'd0);
      $display("auto step %0d: count=%0d status=%0d", i + 1, steps[i].exp_count, steps[i].exp_status);
    end
    check_reg("auto_ctrl_off", A_CTRL, 32'h0);

    // ---------------- reset mid-count ----------------
    bus_write(A_LOAD, 32'd5);
    bus_write(A_CTRL, 32'h5);
    tick();
    tick();
    check_reg("run_count_pre_rst", A_CNT, 32'd3);
    reset = 1'b0;
    #1;
    check_reg("mid_rst_count", A_CNT, 32'd0);
    check_reg("mid_rst_ctrl", A_CTRL, 32'd0);
    tick();
    reset = 1'b1;
    repeat (10) tick();
    check_reg("post_rst_count", A_CNT, 32'd0);
    check_reg("post_rst_status", A_STAT, 32'd0);
    check_reg("post_rst_ctrl", A_CTRL, 32'd0);
    check_reg("post_rst_load", A_LOAD, 32'd0);
    check("post_rst_irq", {31'd0, irq}, 32'd0);
    $display("reset sequence done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
